// File: rtl/seq_detector_param.sv
// Serial pattern detector: one-cycle match pulse, overlap option, saturating match counter.
// Optional build macro SEQ_DET_MASK_EN adds mask_i, a per-position don't-care mask.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 3
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           en_i,
  input  logic                           in_i,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0]             mask_i,
`endif
  input  logic                           clr_i,
  output logic                           match_o,
  output logic [$clog2(PAT_LEN+1)-1:0]   progress_o,
  output logic [CNT_W-1:0]               count_o,
  output logic                           sat_o
);

  localparam int               FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0]    NEAR = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [0:0]       ST_FILL  = 1'b0;
  localparam logic [0:0]       ST_ARMED = 1'b1;

  logic [PAT_LEN-1:0] hist_r;
  logic [PAT_LEN-1:0] hist_next_s;
  logic [PAT_LEN-1:0] care_s;
  logic [FW-1:0]      fill_r;
  logic [FW-1:0]      fill_next_s;
  logic [0:0]         state_r;
  logic [0:0]         state_next_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_next_s;
  logic               match_r;
  logic               sat_r;
  logic               hit_s;

  // Next-sample compare and the fill/state/counter updates it implies.
  always_comb begin
`ifdef SEQ_DET_MASK_EN
    care_s = ~mask_i;
`else
    care_s = {PAT_LEN{1'b1}};
`endif
    hist_next_s  = {hist_r[PAT_LEN-2:0], in_i};
    hit_s        = (fill_r >= NEAR) &&
                   (((hist_next_s ^ PATTERN) & care_s) == {PAT_LEN{1'b0}});
    fill_next_s  = fill_r;
    state_next_s = state_r;
    count_next_s = count_r;
    if (hit_s) begin
      if (OVERLAP) begin
        fill_next_s  = FULL;
        state_next_s = ST_ARMED;
      end else begin
        fill_next_s  = {FW{1'b0}};
        state_next_s = ST_FILL;
      end
      if (count_r == CMAX) begin
        count_next_s = count_r;
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      // Once armed the window stays full; otherwise it grows by one sample.
      if (state_r == ST_ARMED) begin
        fill_next_s = FULL;
      end else begin
        fill_next_s = fill_r + FW'(1);
      end
      if (fill_next_s == FULL) begin
        state_next_s = ST_ARMED;
      end else begin
        state_next_s = ST_FILL;
      end
    end
  end

  // State registers: reset, then clear, then enabled sample, else hold.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hist_r  <= {PAT_LEN{1'b0}};
      fill_r  <= {FW{1'b0}};
      state_r <= ST_FILL;
      count_r <= {CNT_W{1'b0}};
      match_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (clr_i) begin
      hist_r  <= {PAT_LEN{1'b0}};
      fill_r  <= {FW{1'b0}};
      state_r <= ST_FILL;
      count_r <= {CNT_W{1'b0}};
      match_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (en_i) begin
      hist_r  <= hist_next_s;
      fill_r  <= fill_next_s;
      state_r <= state_next_s;
      count_r <= count_next_s;
      match_r <= hit_s;
      sat_r   <= (count_next_s == CMAX);
    end else begin
      match_r <= 1'b0;
    end
  end

  assign match_o    = match_r;
  assign progress_o = fill_r;
  assign count_o    = count_r;
  assign sat_o      = sat_r;

endmodule
